// File: rtl/frame13_pkg.sv
// -----------------------------------------------------------------------------
// frame13_pkg
// Shared constants and types for the 13-bit framed serial receiver.
//   FRAME_LEN : bits per frame (header 3 + data 5 + trailer 5)
//   HDR       : header bits, first three on the wire
//   TRL       : trailer bits, last five on the wire
//   state_e   : receiver synchronisation states
// -----------------------------------------------------------------------------
package frame13_pkg;

    localparam int          FRAME_LEN = 13;
    localparam int          DATA_W    = 5;
    localparam logic [2:0]  HDR       = 3'b110;
    localparam logic [4:0]  TRL       = 5'b01011;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/frame13_match.sv
// -----------------------------------------------------------------------------
// frame13_match
// Combinational frame detector. Looks at a full 13-bit window (oldest bit in
// the MSB) and reports whether it holds a well-formed frame.
//   nsr_i   : 13-bit candidate window, bit 12 received first
//   match_o : 1 when header and trailer both match
//   data_o  : the five data bits, d1 in bit 4 down to d5 in bit 0
// -----------------------------------------------------------------------------
module frame13_match
    import frame13_pkg::*;
(
    input  logic [FRAME_LEN-1:0] nsr_i,
    output logic                 match_o,
    output logic [DATA_W-1:0]    data_o
);

    assign match_o = (nsr_i[12:10] == HDR) && (nsr_i[4:0] == TRL);
    assign data_o  = nsr_i[9:5];

endmodule

// File: rtl/frame13_rx.sv
// -----------------------------------------------------------------------------
// frame13_rx
// Serial receiver for a continuously repeating 13-bit frame
// (1 1 0 d1..d5 0 1 0 1 1). Hunts for the frame pattern on every sampled bit,
// confirms it over SYNC_FRAMES consecutive frames, then tracks frame
// boundaries and drops lock after LOSS_ERRS consecutive bad frames.
//   io_in[0]    : clock
//   io_in[1]    : synchronous active-high reset
//   io_in[2]    : serial data in
//   io_in[3]    : bit-sample enable
//   io_in[7:4]  : ignored
//   io_out[4:0] : payload (d1 in bit 4)
//   io_out[5]   : locked
//   io_out[6]   : strobe, one cycle per good frame while locked
//   io_out[7]   : err, one cycle per bad frame while locked
// -----------------------------------------------------------------------------
module frame13_rx
    import frame13_pkg::*;
#(
    parameter int unsigned SYNC_FRAMES = 2,
    parameter int unsigned LOSS_ERRS   = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [3:0] CNT_LAST = 4'(FRAME_LEN - 1);
    localparam logic [2:0] SYNC_N   = 3'(SYNC_FRAMES);
    localparam logic [2:0] LOSS_N   = 3'(LOSS_ERRS);

    logic clk;
    logic srst;
    logic sdin;
    logic sd_en;

    assign clk   = io_in[0];
    assign srst  = io_in[1];
    assign sdin  = io_in[2];
    assign sd_en = io_in[3];

    logic [FRAME_LEN-1:0] sr_q;
    logic [3:0]           cnt_q;
    logic [2:0]           good_q;
    logic [2:0]           miss_q;
    state_e               state_q;
    logic [DATA_W-1:0]    payload_q;
    logic                 locked_q;
    logic                 strobe_q;
    logic                 err_q;

    // Next-state views used by the FSM below.
    logic [FRAME_LEN-1:0] sr_d;
    logic [3:0]           cnt_d;
    logic [2:0]           good_d;
    logic [2:0]           miss_d;
    logic                 match;
    logic [DATA_W-1:0]    frame_data;
    logic                 frame_end;

    // Matching is done on the window that includes the bit arriving this
    // edge, so a frame is recognised on the very edge of its last bit.
    assign sr_d      = {sr_q[FRAME_LEN-2:0], sdin};
    assign cnt_d     = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    assign good_d    = good_q + 3'd1;
    assign miss_d    = miss_q + 3'd1;
    assign frame_end = (cnt_q == CNT_LAST);

    frame13_match u_match (
        .nsr_i   (sr_d),
        .match_o (match),
        .data_o  (frame_data)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            sr_q      <= '0;
            cnt_q     <= 4'd0;
            good_q    <= 3'd0;
            miss_q    <= 3'd0;
            state_q   <= ST_HUNT;
            payload_q <= '0;
            locked_q  <= 1'b0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Pulses last exactly one cycle; only an enabled edge can set them.
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            if (sd_en) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_d;
                case (state_q)
                    ST_HUNT: begin
                        if (match) begin
                            // Realign the bit counter to the detected boundary.
                            cnt_q  <= 4'd0;
                            good_q <= 3'd1;
                            if (SYNC_N == 3'd1) begin
                                state_q   <= ST_LOCKED;
                                payload_q <= frame_data;
                                strobe_q  <= 1'b1;
                                locked_q  <= 1'b1;
                                miss_q    <= 3'd0;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (frame_end) begin
                            if (match) begin
                                good_q <= good_d;
                                if (good_d == SYNC_N) begin
                                    state_q   <= ST_LOCKED;
                                    payload_q <= frame_data;
                                    strobe_q  <= 1'b1;
                                    locked_q  <= 1'b1;
                                    miss_q    <= 3'd0;
                                end
                            end else begin
                                state_q <= ST_HUNT;
                                good_q  <= 3'd0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (frame_end) begin
                            if (match) begin
                                payload_q <= frame_data;
                                strobe_q  <= 1'b1;
                                miss_q    <= 3'd0;
                            end else begin
                                // Bad frame: flag it, keep the last good payload.
                                err_q <= 1'b1;
                                if (miss_d == LOSS_N) begin
                                    state_q  <= ST_HUNT;
                                    locked_q <= 1'b0;
                                    miss_q   <= 3'd0;
                                    good_q   <= 3'd0;
                                end else begin
                                    miss_q <= miss_d;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign io_out = {err_q, strobe_q, locked_q, payload_q};

    // The oldest shift-register bit falls off without being examined, and the
    // upper input pins carry nothing.
    logic unused_bits;
    assign unused_bits = ^{io_in[7:4], sr_q[FRAME_LEN-1]};

endmodule

// File: tb/tb_frame13_rx.sv
// -----------------------------------------------------------------------------
// tb_frame13_rx
// Directed bench for frame13_rx with default parameters (SYNC 2, LOSS 2).
// Expected output bytes are {err, strobe, locked, payload[4:0]}.
// -----------------------------------------------------------------------------
module tb_frame13_rx;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       sdin  = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] spare = 4'b1010;
    logic [7:0] io_in_w;
    logic [7:0] io_out;

    assign io_in_w = {spare, en, sdin, rst, clk};

    frame13_rx #(
        .SYNC_FRAMES (2),
        .LOSS_ERRS   (2)
    ) dut (
        .io_in  (io_in_w),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         mid_pulses  = 0;
    int         idle_pulses = 0;
    int         both_pulses = 0;
    logic [7:0] en_out      = 8'h00;
    logic [7:0] fr_out      = 8'h00;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, observe 1 ns after rising.
    task automatic tick(input logic b, input logic e, input logic r);
        @(negedge clk);
        sdin = b;
        en   = e;
        rst  = r;
        @(posedge clk);
        #1;
        if (io_out[6] && io_out[7]) both_pulses++;
    endtask

    task automatic send_bit(input logic b, input bit half);
        tick(b, 1'b1, 1'b0);
        en_out = io_out;
        if (half) begin
            tick(1'b0, 1'b0, 1'b0);
            if (io_out[6] || io_out[7]) idle_pulses++;
        end
    endtask

    task automatic send_frame(input logic [4:0] d, input logic [4:0] trl, input bit half);
        logic [12:0] bits;
        bits = {3'b110, d, trl};
        for (int i = 12; i >= 0; i--) begin
            send_bit(bits[i], half);
            if (i != 0 && (en_out[6] || en_out[7])) mid_pulses++;
        end
        fr_out = en_out;
        $display("frame d=%b trl=%b half=%0d -> err=%0d strobe=%0d locked=%0d payload=%b",
                 d, trl, half, fr_out[7], fr_out[6], fr_out[5], fr_out[4:0]);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        $display("reset -> out=%b", io_out);
    endtask

    initial begin
        logic [4:0]  prefix;
        logic [12:0] fbits;

        // Reset values
        do_reset();
        chk("reset_out", io_out, 8'h00);

        // Basic acquisition, full rate
        send_frame(5'b10110, 5'b01011, 1'b0);
        chk("acq_f1", fr_out, 8'h00);
        send_frame(5'b10110, 5'b01011, 1'b0);
        chk("acq_lock", fr_out, 8'h76);
        send_frame(5'b10110, 5'b01011, 1'b0);
        chk("acq_f3", fr_out, 8'h76);
        send_frame(5'b10110, 5'b01011, 1'b0);
        chk("acq_f4", fr_out, 8'h76);

        // Single bad frame, then recovery; a second isolated bad frame
        // must not drop lock because the miss count was cleared.
        send_frame(5'b10110, 5'b01111, 1'b0);
        chk("bad1_err", fr_out, 8'hB6);
        send_frame(5'b11100, 5'b01011, 1'b0);
        chk("recover", fr_out, 8'h7C);
        send_frame(5'b11100, 5'b01111, 1'b0);
        chk("miss_cleared", fr_out, 8'hBC);
        send_frame(5'b00111, 5'b01011, 1'b0);
        chk("recover2", fr_out, 8'h67);

        // Two consecutive bad frames drop lock, payload held
        send_frame(5'b00111, 5'b01111, 1'b0);
        chk("loss_b1", fr_out, 8'hA7);
        send_frame(5'b00111, 5'b01111, 1'b0);
        chk("loss_b2", fr_out, 8'h87);
        tick(1'b0, 1'b0, 1'b0);
        chk("loss_hold", io_out, 8'h07);

        // Misaligned start: prefix bits, then frames d=00001
        do_reset();
        chk("reset2_out", io_out, 8'h00);
        prefix = 5'b10010;
        for (int i = 4; i >= 0; i--) send_bit(prefix[i], 1'b0);
        chk("prefix_out", en_out, 8'h00);
        send_frame(5'b00001, 5'b01011, 1'b0);
        chk("align_f1", fr_out, 8'h00);
        send_frame(5'b00001, 5'b01011, 1'b0);
        chk("align_lock", fr_out, 8'h61);

        // Half-rate sampling
        do_reset();
        send_frame(5'b10110, 5'b01011, 1'b1);
        chk("half_f1", fr_out, 8'h00);
        send_frame(5'b10110, 5'b01011, 1'b1);
        chk("half_lock", fr_out, 8'h76);
        send_frame(5'b10110, 5'b01011, 1'b1);
        chk("half_f3", fr_out, 8'h76);
        chk("idle_pulses", 8'(idle_pulses), 8'h00);
        chk("half_idle_out", io_out, 8'h36);

        // Reset in the middle of a locked frame, then relock
        send_frame(5'b10110, 5'b01011, 1'b0);
        chk("pre_rst", fr_out, 8'h76);
        fbits = {3'b110, 5'b11001, 5'b01011};
        for (int i = 12; i > 6; i--) send_bit(fbits[i], 1'b0);
        tick(fbits[6], 1'b1, 1'b1);
        $display("mid-frame reset -> out=%b", io_out);
        chk("midrst_out", io_out, 8'h00);
        send_frame(5'b11001, 5'b01011, 1'b0);
        chk("relock_f1", fr_out, 8'h00);
        send_frame(5'b11001, 5'b01011, 1'b0);
        chk("relock", fr_out, 8'h79);

        chk("mid_pulses", 8'(mid_pulses), 8'h00);
        chk("both_pulses", 8'(both_pulses), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame13_rx.md
FRAME13_RX -- requirements
Module: frame13_rx

Interface
REQ-001 SYNC_FRAMES, default 2: number of consecutive good frames needed to declare lock, legal range 1..7.
REQ-002 LOSS_ERRS, default 2: number of consecutive bad frames while locked that drop lock, legal range 1..7.
REQ-003 io_in[0]  input  1  clock; one clock, all state updates on its rising edge.
REQ-004 io_in[1]  input  1  reset; synchronous and active-high.
REQ-005 io_in[2]  input  1  sdin; serial data, sampled on the rising edge when sd_en=1.
REQ-006 io_in[3]  input  1  sd_en; bit-sample enable (1 = sample this cycle).
REQ-007 io_in[7:4]  input  4  unused, ignored.
REQ-008 io_out[4:0]  output  5  payload; io_out[4] is first-received data bit d1, io_out[0] is d5.
REQ-009 io_out[5]  output  1  locked.
REQ-010 io_out[6]  output  1  strobe; one-cycle pulse when a good frame updates payload while locked.
REQ-011 io_out[7]  output  1  err; one-cycle pulse on each bad frame while locked.

Function
REQ-012 Frame SHALL be 13 bits in transmission order: 1 1 0 d1 d2 d3 d4 d5 0 1 0 1 1; the block repeats continuously.
REQ-013 On each sd_en=1 edge, sr[12:0] SHALL load {sr[11:0], sdin}; on sd_en=0 all state holds, strobe=0, err=0.
REQ-014 Match SHALL be evaluated on the next value nsr={sr[11:0],sdin}: nsr[12:10]=110 and nsr[4:0]=01011; frame data = nsr[9:5].
REQ-015 States SHALL be HUNT, CHECK, LOCKED; a 4-bit bit counter cnt counts 0..12 on enabled edges and wraps to 0.
REQ-016 HUNT: every enabled edge is evaluated; on match, cnt<=0 and good<=1; go to LOCKED if SYNC_FRAMES=1, else CHECK.
REQ-017 CHECK: evaluation only on the enabled edge with cnt=12; match increments good, reaching SYNC_FRAMES goes to LOCKED; mismatch returns to HUNT, good<=0.
REQ-018 Entering LOCKED SHALL load payload from frame data, assert strobe and locked, clear miss counter.
REQ-019 LOCKED: at cnt=12 enabled edge, match loads payload, pulses strobe, clears miss; mismatch pulses err, holds payload, increments miss.
REQ-020 When miss reaches LOSS_ERRS, the same edge SHALL go to HUNT, deassert locked, keep payload unchanged.
REQ-021 Latency: strobe/err/payload/locked SHALL be visible in the cycle following the edge sampling a frame's last bit.
REQ-022 strobe and err SHALL never be asserted in the same cycle; neither is asserted outside LOCKED except the lock-entry strobe.
REQ-023 cnt, good and miss SHALL saturate/wrap only as defined; no counter overflows with legal parameters.

Reset
REQ-024 Reset SHALL take priority over sd_en and all evaluation.
REQ-025 Reset values: sr=0, cnt=0, good=0, miss=0, state HUNT, payload=00000, locked=0, strobe=0, err=0.
REQ-026 Reset asserted mid-frame or while locked SHALL abandon the frame; reacquisition starts from HUNT.

Structure
REQ-027 Package frame13_pkg SHALL hold FRAME_LEN=13, HDR=3'b110, TRL=5'b01011, and the state enumeration.
REQ-028 One sub-module frame13_match (combinational: nsr in -> match, data out) SHALL be used; the FSM and counters stay in frame13_rx.

Verification
REQ-029 Reset, then stream frame 110 10110 01011 repeated with sd_en=1 -> locked=1 and payload=10110 one cycle after bit 26; strobe every 13 cycles thereafter.
REQ-030 Prefix 5 random bits not containing the pattern, then frames with d=00001 -> lock after 2 frames aligned to the true boundary, payload=00001.
REQ-031 Locked, then one frame with trailer 01111 then good frame d=11100 -> single err pulse, locked stays 1, payload then 11100, miss cleared.
REQ-032 Locked, then two consecutive bad frames -> two err pulses, locked=0 after the second, payload retains last good value.
REQ-033 Stream with sd_en toggling 1,0 each cycle -> identical results to REQ-029 at half rate; no pulses on sd_en=0 cycles.
REQ-034 Reset asserted at bit 7 of a locked frame -> all outputs 0 next cycle; relock after SYNC_FRAMES full frames.
